// File: rtl/ofifo_col.sv
// Output FIFO bank behind the SFP stage: one FIFO per column, written per column,
// popped as a full row. out is registered and only changes on an accepted pop.
module ofifo_col #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [psum_bw*col-1:0]   in,
  input  logic [col-1:0]           wr,
  input  logic                     rd,
  output logic [psum_bw*col-1:0]   out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     o_overflow
);

  localparam int aw = $clog2(depth);

  // Handshake: a row pop happens at a rising edge where rd && o_valid;
  // column k accepts a word at an edge where wr[k] && (column not full || pop).
  logic [psum_bw-1:0]     mem_q [col][depth];
  logic [aw:0]            wr_ptr_q [col];
  logic [aw:0]            wr_ptr_d [col];
  logic [aw:0]            rd_ptr_q [col];
  logic [aw:0]            rd_ptr_d [col];
  logic [psum_bw*col-1:0] out_q, out_d;
  logic                   overflow_q, overflow_d;

  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         push_ok;
  logic                   pop;

  always_comb begin
    for (int k = 0; k < col; k++) begin
      empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
      full[k]  = (wr_ptr_q[k][aw-1:0] == rd_ptr_q[k][aw-1:0]) &&
                 (wr_ptr_q[k][aw] != rd_ptr_q[k][aw]);
    end
  end

  assign o_valid    = &(~empty);
  assign o_full     = |full;
  assign o_ready    = ~o_full;
  assign pop        = rd & o_valid;
  assign out        = out_q;
  assign o_overflow = overflow_q;

  always_comb begin
    out_d      = out_q;
    overflow_d = overflow_q;
    for (int k = 0; k < col; k++) begin
      // A pop in the same edge frees the slot, so a full column still accepts.
      push_ok[k]  = wr[k] & (~full[k] | pop);
      wr_ptr_d[k] = push_ok[k] ? wr_ptr_q[k] + 1'b1 : wr_ptr_q[k];
      rd_ptr_d[k] = pop ? rd_ptr_q[k] + 1'b1 : rd_ptr_q[k];
      if (pop) begin
        out_d[k*psum_bw +: psum_bw] = mem_q[k][rd_ptr_q[k][aw-1:0]];
      end
    end
    if (|(wr & ~push_ok)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < col; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int k = 0; k < col; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
      end
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; emptiness is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < col; k++) begin
      if (push_ok[k]) begin
        mem_q[k][wr_ptr_q[k][aw-1:0]] <= in[k*psum_bw +: psum_bw];
      end
    end
  end

endmodule

// File: tb/tb_ofifo_col.sv
// Bench for ofifo_col: queue-per-column reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ofifo_col;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int W     = COL * BW;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in_d;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out_d;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
  logic           o_overflow;

  int checks   = 0;
  int failures = 0;

  ofifo_col #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in         (in_d),
    .wr         (wr),
    .rd         (rd),
    .out        (out_d),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: one queue per column
  logic [BW-1:0] exp_q [COL][$];
  logic [W-1:0]  exp_out = '0;
  logic          exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic m_valid;
    if (rst_n) begin
      m_valid = 1'b1;
      for (int k = 0; k < COL; k++) if (exp_q[k].size() == 0) m_valid = 1'b0;
      if (rd && m_valid)
        for (int k = 0; k < COL; k++) exp_out[k*BW +: BW] = exp_q[k].pop_front();
      for (int k = 0; k < COL; k++) begin
        if (wr[k]) begin
          if (exp_q[k].size() < DEPTH) exp_q[k].push_back(in_d[k*BW +: BW]);
          else exp_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < COL; k++) exp_q[k].delete();
    exp_out = '0;
    exp_ovf = 1'b0;
  end

  // compare process
  always @(negedge clk) begin
    logic e_valid, e_full;
    e_valid = 1'b1;
    e_full  = 1'b0;
    for (int k = 0; k < COL; k++) begin
      if (exp_q[k].size() == 0) e_valid = 1'b0;
      if (exp_q[k].size() == DEPTH) e_full = 1'b1;
    end
    chk("m_out", out_d, exp_out);
    chk("m_valid", {{(W-1){1'b0}}, o_valid}, {{(W-1){1'b0}}, e_valid});
    chk("m_full", {{(W-1){1'b0}}, o_full}, {{(W-1){1'b0}}, e_full});
    chk("m_ready", {{(W-1){1'b0}}, o_ready}, {{(W-1){1'b0}}, ~e_full});
    chk("m_ovf", {{(W-1){1'b0}}, o_overflow}, {{(W-1){1'b0}}, exp_ovf});
  end

  // driver tasks
  task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
    wr   = w;
    in_d = d;
    rd   = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    wr = '0;
    rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] row(input int v);
    logic [BW-1:0] x;
    x = BW'(v);
    return {COL{x}};
  endfunction

  initial begin
    logic [W-1:0] e;
    rst_n = 1'b0;
    wr    = '0;
    rd    = 1'b0;
    in_d  = '0;

    // 1 reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", out_d, '0);
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_full", W'(o_full), W'(0));
    chk("rst_ready", W'(o_ready), W'(1));
    chk("rst_ovf", W'(o_overflow), W'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 2 skewed fill
    step(8'h01, row(5), 1'b0);
    chk("skew_valid_1", W'(o_valid), W'(0));
    step(8'hFE, row(7), 1'b0);
    chk("skew_valid_2", W'(o_valid), W'(1));
    step(8'h00, '0, 1'b1);
    e = row(7);
    e[0 +: BW] = 16'd5;
    chk("skew_out", out_d, e);

    // 3 fill to depth, overflow, drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(8'hFF, row(i), 1'b0);
    chk("fill_full", W'(o_full), W'(1));
    chk("fill_ready", W'(o_ready), W'(0));
    chk("fill_ovf0", W'(o_overflow), W'(0));
    step(8'hFF, row(999), 1'b0);
    chk("fill_ovf1", W'(o_overflow), W'(1));
    for (int i = 0; i < DEPTH; i++) begin
      step(8'h00, '0, 1'b1);
      chk("fill_pop", out_d, row(i));
    end
    chk("fill_empty", W'(o_valid), W'(0));
    chk("fill_ovf_sticky", W'(o_overflow), W'(1));

    // 4 full push+pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(8'hFF, row(100 + i), 1'b0);
    step(8'hFF, row(500), 1'b1);
    chk("fpp_out", out_d, row(100));
    chk("fpp_ovf", W'(o_overflow), W'(0));
    chk("fpp_full", W'(o_full), W'(1));
    for (int i = 1; i < DEPTH; i++) step(8'h00, '0, 1'b1);
    chk("fpp_pen", out_d, row(163));
    step(8'h00, '0, 1'b1);
    chk("fpp_last", out_d, row(500));

    // 5 pop while a column is empty
    do_reset();
    step(8'hFF, row(42), 1'b0);
    step(8'h00, '0, 1'b1);
    chk("pe_out42", out_d, row(42));
    step(8'hF7, row(9), 1'b0);
    step(8'h00, '0, 1'b1);
    chk("pe_hold", out_d, row(42));
    chk("pe_valid0", W'(o_valid), W'(0));
    step(8'h08, row(11), 1'b0);
    chk("pe_valid1", W'(o_valid), W'(1));
    step(8'h00, '0, 1'b1);
    e = row(9);
    e[3*BW +: BW] = 16'd11;
    chk("pe_out", out_d, e);

    // 6 async reset mid-stream
    do_reset();
    for (int i = 0; i < 10; i++) step(8'hFF, row(20 + i), 1'b0);
    step(8'h00, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(8'h01, row(300 + i), 1'b0);
    chk("ar_pre_ovf", W'(o_overflow), W'(1));
    chk("ar_pre_full", W'(o_full), W'(1));
    step(8'hFF, row(77), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_out", out_d, '0);
    chk("ar_valid", W'(o_valid), W'(0));
    chk("ar_full", W'(o_full), W'(0));
    chk("ar_ovf", W'(o_overflow), W'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(8'h00, '0, 1'b1);
    chk("ar_rel_out", out_d, '0);
    chk("ar_rel_valid", W'(o_valid), W'(0));
    step(8'hFF, row(3), 1'b0);
    step(8'h00, '0, 1'b1);
    chk("ar_after", out_d, row(3));

    step(8'h00, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
